// File: rtl/rtr_inp_vc_logic.sv
// Router input stage with VC_NUM virtual channels. Each VC has its own FIFO, its own
// route computation from the head flit's destination field, and an output lock that is
// held from a granted HEAD until its TAIL. A round-robin arbiter offers one eligible VC
// per cycle to the switch allocator. Upstream flow control is credit based.
//
// Flit type lives in data_in[1:0]: 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 SINGLE.
//
// Handshake: sa_req is a one-hot (or zero) port request for the VC shown on vc_out and
// data_out; sa_grant in the same cycle accepts that flit, which pops the VC at the
// clock edge. sa_grant must only be raised while sa_req is non-zero.
module rtr_inp_vc_logic #(
    parameter int FLIT_WIDTH     = 16,
    parameter int VC_NUM         = 2,
    parameter int VC_DEPTH       = 4,
    parameter int NODE_ID        = 0,
    parameter int MY_INP_ID      = 0,
    parameter int DST_PNT        = 4,
    parameter int DST_ADDR_WIDTH = 2,
    parameter int RC_ALGO        = 0,    // 0 = RC_ALGO_XBAR (crossbar, port = dst)
    parameter int OUT_PORTS      = 4,
    parameter bit NO_RETURNS     = 1'b0,
    localparam int NP = OUT_PORTS - (NO_RETURNS ? 1 : 0),
    localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic [VW-1:0]         vc_in,
    output logic [VC_NUM-1:0]     credit_out,
    output logic [NP-1:0]         sa_req,
    input  logic                  sa_grant,
    input  logic [NP-1:0]         ready_outps,
    input  logic [NP-1:0]         avail_outps,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [VW-1:0]         vc_out,
    output logic [VC_NUM-1:0]     vc_locked_o     // debug view of the per-VC lock FSM
);

    localparam int RC_ALGO_XBAR = 0;
    localparam int PW = $clog2(VC_DEPTH);
    localparam int CW = $clog2(VC_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(VC_DEPTH);

    typedef enum logic { VC_UNLOCKED = 1'b0, VC_LOCKED = 1'b1 } vc_state_e;

    // Parameter sanity, resolved at elaboration
    if (RC_ALGO != RC_ALGO_XBAR) begin : g_bad_algo
        $fatal(1, "rtr_inp_vc_logic: only the crossbar routing algorithm is supported");
    end
    if (VC_NUM < 1 || VC_DEPTH < 2 || NODE_ID < 0) begin : g_bad_size
        $fatal(1, "rtr_inp_vc_logic: VC_NUM>=1, VC_DEPTH>=2, NODE_ID>=0 required");
    end
    if (DST_ADDR_WIDTH == 0 && (OUT_PORTS != 1 || NO_RETURNS)) begin : g_bad_const_route
        $fatal(1, "rtr_inp_vc_logic: constant route needs OUT_PORTS=1 and NO_RETURNS=0");
    end
    if (NO_RETURNS && (OUT_PORTS < 2 || MY_INP_ID < 0 || MY_INP_ID >= OUT_PORTS)) begin : g_bad_ret
        $fatal(1, "rtr_inp_vc_logic: MY_INP_ID must name a valid output when NO_RETURNS=1");
    end

    function automatic logic is_head(input logic [1:0] t);
        return t == 2'b10;
    endfunction

    function automatic logic ends_pkt(input logic [1:0] t);   // TAIL or SINGLE
        return t[0];
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(VC_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic int wrap_idx(input int a);
        return (a >= VC_NUM) ? a - VC_NUM : a;
    endfunction

    logic [FLIT_WIDTH-1:0]       mem_q [VC_NUM][VC_DEPTH];
    logic [PW-1:0]               rd_ptr_q [VC_NUM];
    logic [PW-1:0]               rd_ptr_d [VC_NUM];
    logic [PW-1:0]               wr_ptr_q [VC_NUM];
    logic [PW-1:0]               wr_ptr_d [VC_NUM];
    logic [CW-1:0]               cnt_q [VC_NUM];
    logic [CW-1:0]               cnt_d [VC_NUM];
    vc_state_e                   state_q [VC_NUM];
    vc_state_e                   state_d [VC_NUM];
    logic [VC_NUM-1:0][NP-1:0]   out_port_q, out_port_d;
    logic [VC_NUM-1:0][NP-1:0]   route, port_vec;
    logic [FLIT_WIDTH-1:0]       head [VC_NUM];
    logic [VC_NUM-1:0]           elig, push_v, pop_v, credit_q;
    logic [VW-1:0]               sel, rr_ptr_q, rr_ptr_d;
    logic                        found, grant_ok;

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        logic [OUT_PORTS-1:0] route_full;
        logic [NP-1:0]        route_np;

        assign head[v] = mem_q[v][rd_ptr_q[v]];

        if (DST_ADDR_WIDTH == 0) begin : g_const
            assign route_full = OUT_PORTS'(1);
        end else begin : g_xbar
            logic [DST_ADDR_WIDTH-1:0] dst;
            assign dst = head[v][DST_PNT +: DST_ADDR_WIDTH];
            // Crossbar routing: one-hot port equal to the destination field
            always_comb begin
                route_full = '0;
                for (int p = 0; p < OUT_PORTS; p++) begin
                    if (int'(dst) == p) route_full[p] = 1'b1;
                end
            end
        end

        if (NO_RETURNS) begin : g_compact
            // Drop the bit for our own output and close the gap above it
            always_comb begin
                route_np = '0;
                for (int p = 0; p < OUT_PORTS; p++) begin
                    if (p < MY_INP_ID)      route_np[p]     = route_full[p];
                    else if (p > MY_INP_ID) route_np[p - 1] = route_full[p];
                end
            end
        end else begin : g_full
            assign route_np = route_full;
        end

        assign route[v]       = route_np;
        assign vc_locked_o[v] = (state_q[v] == VC_LOCKED);

        // Protocol violations: overflow, mid-packet flit without a lock, grant with no request
        a_no_overflow: assert property (@(posedge clk) disable iff (rst)
            !(valid_in && int'(vc_in) == v && cnt_q[v] == FULL_CNT && !pop_v[v]))
            else $fatal(1, "push to full VC %0d", v);
        a_head_first: assert property (@(posedge clk) disable iff (rst)
            !(cnt_q[v] != '0 && state_q[v] == VC_UNLOCKED && !head[v][1]))
            else $fatal(1, "BODY/TAIL at head of unlocked VC %0d", v);
    end

    a_vc_range: assert property (@(posedge clk) disable iff (rst)
        !(valid_in && int'(vc_in) >= VC_NUM))
        else $fatal(1, "vc_in out of range");
    a_grant_req: assert property (@(posedge clk) disable iff (rst) !(sa_grant && !found))
        else $fatal(1, "sa_grant without sa_req");

    // Per-VC eligibility and requested port vector
    always_comb begin
        elig     = '0;
        port_vec = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            port_vec[v] = (state_q[v] == VC_LOCKED) ? out_port_q[v] : route[v];
            if (cnt_q[v] != '0) begin
                if (state_q[v] == VC_LOCKED)
                    elig[v] = |(out_port_q[v] & ready_outps);
                else
                    elig[v] = head[v][1] && |(route[v] & avail_outps & ready_outps);
            end
        end
    end

    // Round-robin pick starting at the pointer; drives the SA-facing outputs
    always_comb begin
        logic [VW-1:0] cand;
        cand  = '0;
        sel   = rr_ptr_q;
        found = 1'b0;
        for (int i = 0; i < VC_NUM; i++) begin
            cand = VW'(wrap_idx(int'(rr_ptr_q) + i));
            if (!found && elig[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        sa_req   = found ? port_vec[sel] : '0;
        data_out = head[sel];
        vc_out   = sel;
        grant_ok = sa_grant && found;
        rr_ptr_d = rr_ptr_q;
        if (grant_ok) rr_ptr_d = (sel == VW'(VC_NUM - 1)) ? '0 : sel + 1'b1;
    end

    // FIFO push/pop decisions and next pointers/occupancy; a full VC accepts only while popping
    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            pop_v[v]    = grant_ok && (sel == VW'(v));
            push_v[v]   = valid_in && (int'(vc_in) == v) && ((cnt_q[v] != FULL_CNT) || pop_v[v]);
            rd_ptr_d[v] = pop_v[v]  ? ptr_inc(rd_ptr_q[v]) : rd_ptr_q[v];
            wr_ptr_d[v] = push_v[v] ? ptr_inc(wr_ptr_q[v]) : wr_ptr_q[v];
            case ({push_v[v], pop_v[v]})
                2'b10:   cnt_d[v] = cnt_q[v] + 1'b1;
                2'b01:   cnt_d[v] = cnt_q[v] - 1'b1;
                default: cnt_d[v] = cnt_q[v];
            endcase
        end
    end

    // Lock FSM: a granted HEAD locks its route, a granted TAIL/SINGLE releases it
    always_comb begin
        out_port_d = out_port_q;
        for (int v = 0; v < VC_NUM; v++) begin
            state_d[v] = state_q[v];
            if (pop_v[v]) begin
                if (is_head(head[v][1:0])) begin
                    state_d[v]    = VC_LOCKED;
                    out_port_d[v] = route[v];
                end else if (ends_pkt(head[v][1:0])) begin
                    state_d[v] = VC_UNLOCKED;
                end
            end
        end
    end

    // Flit storage; contents are meaningless while a VC is empty, so no reset
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (push_v[v]) mem_q[v][wr_ptr_q[v]] <= data_in;
        end
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                rd_ptr_q[v] <= '0;
                wr_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
                state_q[v]  <= VC_UNLOCKED;
            end
            out_port_q <= '0;
            rr_ptr_q   <= '0;
            credit_q   <= '0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                rd_ptr_q[v] <= rd_ptr_d[v];
                wr_ptr_q[v] <= wr_ptr_d[v];
                cnt_q[v]    <= cnt_d[v];
                state_q[v]  <= state_d[v];
            end
            out_port_q <= out_port_d;
            rr_ptr_q   <= rr_ptr_d;
            credit_q   <= pop_v;
        end
    end

    assign credit_out = credit_q;

endmodule
